// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard, exception and interrupt controller.
//   Picks one action per cycle with priority branch > exception > interrupt >
//   load-use > jump > none, and drives the pipeline stall/flush controls.
// Ports:
//   clk, reset                    clock, async active-high reset
//   ID_rs/ID_rt/ID_UsesRs/Rt      ID source operands and their use flags
//   ID_valid, ID_PC               ID slot occupancy and PC
//   ID_illop, ID_eret, ID_jump    ID instruction class
//   EX_MemRd, EX_WrReg            EX load and its destination register
//   EX_branch_taken               EX branch resolved taken
//   irq                           level-sensitive interrupt request
//   stall_PC, stall_IFID          hold PC / IF-ID
//   flush_IFID, bubble_IDEX       squash IF-ID / inject bubble into ID-EX
//   pc_sel                        0 normal, 1 interrupt vector, 2 exception vector
//   irq_ack                       interrupt accepted this cycle
//   epc, kmode, stall_cnt         registered return PC, kernel mode, load-use count
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_valid,
  input  logic [31:0] ID_PC,
  input  logic        ID_illop,
  input  logic        ID_eret,
  input  logic        ID_jump,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_WrReg,
  input  logic        EX_branch_taken,
  input  logic        irq,
  output logic        stall_PC,
  output logic        stall_IFID,
  output logic        flush_IFID,
  output logic        bubble_IDEX,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc,
  output logic        kmode,
  output logic        irq_ack,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] PC_NORMAL = 2'd0;
  localparam logic [1:0] PC_IRQ    = 2'd1;
  localparam logic [1:0] PC_EXC    = 2'd2;
  localparam logic [31:0] EPC_RST  = 32'h8000_0000;

  logic lu, take_irq, take_exc, eret_v;
  logic act_br, act_exc, act_irq, act_lu, act_jmp, eret_clr;

  assign lu = EX_MemRd & (EX_WrReg != 5'd0) &
              ((ID_UsesRs & (EX_WrReg == ID_rs)) | (ID_UsesRt & (EX_WrReg == ID_rt)));
  assign take_irq = irq & ~kmode & ~ID_PC[31] & ID_valid;
  assign take_exc = ID_illop & ID_valid;
  assign eret_v   = ID_eret & ID_valid;

  // Every action is gated by ~reset so the controls read idle while reset is
  // held, independent of the clock. An eret in ID suppresses the interrupt so
  // the kmode clear lands first and the interrupt is taken on a later cycle.
  assign act_br   = ~reset & EX_branch_taken;
  assign act_exc  = ~reset & ~EX_branch_taken & take_exc;
  assign act_irq  = ~reset & ~EX_branch_taken & ~take_exc & take_irq & ~eret_v;
  assign act_lu   = ~reset & ~EX_branch_taken & ~take_exc & ~act_irq & lu;
  assign act_jmp  = ~reset & ~EX_branch_taken & ~take_exc & ~act_irq & ~lu & ID_jump;
  assign eret_clr = ~reset & eret_v & ~EX_branch_taken & ~take_exc & ~lu;

  always_comb begin
    stall_PC    = act_lu;
    stall_IFID  = act_lu;
    flush_IFID  = act_br | act_exc | act_irq | act_jmp;
    bubble_IDEX = act_br | act_exc | act_irq | act_lu;
    irq_ack     = act_irq;
    pc_sel      = PC_NORMAL;
    if (act_exc)      pc_sel = PC_EXC;
    else if (act_irq) pc_sel = PC_IRQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc       <= EPC_RST;
      kmode     <= 1'b1;
      stall_cnt <= 16'd0;
    end else begin
      // Exceptions resume past the faulting instruction; interrupts re-run it.
      if (act_exc) begin
        epc   <= ID_PC + 32'd4;
        kmode <= 1'b1;
      end else if (act_irq) begin
        epc   <= ID_PC;
        kmode <= 1'b1;
      end else if (eret_clr) begin
        kmode <= 1'b0;
      end
      if (act_lu && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step pushes its expected outputs to a
// scoreboard queue; the entry is popped and compared when the DUT is sampled.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_WrReg;
  logic        ID_UsesRs, ID_UsesRt, ID_valid, ID_illop, ID_eret, ID_jump;
  logic [31:0] ID_PC;
  logic        EX_MemRd, EX_branch_taken, irq;
  logic        stall_PC, stall_IFID, flush_IFID, bubble_IDEX, kmode, irq_ack;
  logic [1:0]  pc_sel;
  logic [31:0] epc;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       spc, sif, fl, bub;
    logic [1:0] ps;
    logic       ack;
    logic [31:0] epc;
    logic       km;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_valid(ID_valid), .ID_PC(ID_PC), .ID_illop(ID_illop), .ID_eret(ID_eret),
    .ID_jump(ID_jump), .EX_MemRd(EX_MemRd), .EX_WrReg(EX_WrReg),
    .EX_branch_taken(EX_branch_taken), .irq(irq),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
    .bubble_IDEX(bubble_IDEX), .pc_sel(pc_sel), .epc(epc), .kmode(kmode),
    .irq_ack(irq_ack), .stall_cnt(stall_cnt)
  );

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic expect_now(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    x = sb.pop_front();
    cmp(tag, "stall_PC",    {31'd0, stall_PC},    {31'd0, x.spc});
    cmp(tag, "stall_IFID",  {31'd0, stall_IFID},  {31'd0, x.sif});
    cmp(tag, "flush_IFID",  {31'd0, flush_IFID},  {31'd0, x.fl});
    cmp(tag, "bubble_IDEX", {31'd0, bubble_IDEX}, {31'd0, x.bub});
    cmp(tag, "pc_sel",      {30'd0, pc_sel},      {30'd0, x.ps});
    cmp(tag, "irq_ack",     {31'd0, irq_ack},     {31'd0, x.ack});
    cmp(tag, "epc",         epc,                  x.epc);
    cmp(tag, "kmode",       {31'd0, kmode},       {31'd0, x.km});
    cmp(tag, "stall_cnt",   {16'd0, stall_cnt},   {16'd0, x.cnt});
  endtask

  // Sample on the falling edge, then let the rising edge commit the step.
  task automatic step(input string tag, input exp_t e);
    @(negedge clk);
    expect_now(tag, e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic spc, sif, fl, bub, input logic [1:0] ps,
                              input logic ack, input logic [31:0] ep,
                              input logic km, input logic [15:0] cnt);
    exp_t e;
    e.spc = spc; e.sif = sif; e.fl = fl; e.bub = bub; e.ps = ps;
    e.ack = ack; e.epc = ep; e.km = km; e.cnt = cnt;
    return e;
  endfunction

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_valid = 1'b1; ID_PC = 32'h0040_0000; ID_illop = 1'b0; ID_eret = 1'b0;
    ID_jump = 1'b0; EX_MemRd = 1'b0; EX_WrReg = 5'd0; EX_branch_taken = 1'b0;
    irq = 1'b0;
  endtask

  task automatic set_lu();
    idle_inputs();
    EX_MemRd = 1'b1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_UsesRs = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step("reset", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd0));
    reset = 1'b0;

    set_lu();
    step("loaduse", mk(1,1,0,1,2'd0,0,32'h8000_0000,1,16'd0));
    idle_inputs();
    EX_MemRd = 1'b1; EX_WrReg = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b1;
    step("zero_reg", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd1));
    idle_inputs(); ID_eret = 1'b1;
    step("eret1", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd1));
    idle_inputs(); irq = 1'b1; ID_PC = 32'h0040_0010;
    step("irq_take", mk(0,0,1,1,2'd1,1,32'h8000_0000,0,16'd1));
    ID_PC = 32'h0040_0014;
    step("irq_masked", mk(0,0,0,0,2'd0,0,32'h0040_0010,1,16'd1));
    ID_eret = 1'b1; ID_PC = 32'h0040_0018;
    step("eret_irq", mk(0,0,0,0,2'd0,0,32'h0040_0010,1,16'd1));
    ID_eret = 1'b0; ID_PC = 32'h0040_0030;
    step("irq_after_eret", mk(0,0,1,1,2'd1,1,32'h0040_0010,0,16'd1));
    idle_inputs(); EX_branch_taken = 1'b1; ID_illop = 1'b1; ID_PC = 32'h0040_0034;
    step("br_vs_exc", mk(0,0,1,1,2'd0,0,32'h0040_0030,1,16'd1));
    idle_inputs(); ID_illop = 1'b1; ID_PC = 32'h0040_0020;
    step("illop", mk(0,0,1,1,2'd2,0,32'h0040_0030,1,16'd1));
    idle_inputs(); ID_jump = 1'b1; ID_PC = 32'h0040_0024;
    step("jump", mk(0,0,1,0,2'd0,0,32'h0040_0024,1,16'd1));
    set_lu(); ID_jump = 1'b1;
    step("lu_vs_jump", mk(1,1,0,1,2'd0,0,32'h0040_0024,1,16'd1));
    idle_inputs(); ID_eret = 1'b1;
    step("eret2", mk(0,0,0,0,2'd0,0,32'h0040_0024,1,16'd2));
    idle_inputs(); irq = 1'b1; ID_valid = 1'b0; ID_PC = 32'h0040_0050;
    step("irq_bubble", mk(0,0,0,0,2'd0,0,32'h0040_0024,0,16'd2));
    ID_valid = 1'b1; ID_PC = 32'h8000_0100;
    step("irq_kseg", mk(0,0,0,0,2'd0,0,32'h0040_0024,0,16'd2));
    ID_illop = 1'b1; ID_PC = 32'h0040_0040;
    step("exc_vs_irq", mk(0,0,1,1,2'd2,0,32'h0040_0024,0,16'd2));
    idle_inputs();
    step("exc_commit", mk(0,0,0,0,2'd0,0,32'h0040_0044,1,16'd2));

    // Reset in the middle of a stall cycle: everything snaps back immediately.
    set_lu();
    @(negedge clk);
    expect_now("pre_rst", mk(1,1,0,1,2'd0,0,32'h0040_0044,1,16'd2));
    #2 reset = 1'b1;
    #1 expect_now("rst_async", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd0));
    @(posedge clk); #1;
    expect_now("rst_hold", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd0));
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    step("first_edge", mk(1,1,0,1,2'd0,0,32'h8000_0000,1,16'd1));

    // Saturation: far more than 65535 load-use cycles.
    repeat (65540) @(posedge clk);
    @(negedge clk);
    expect_now("saturate", mk(1,1,0,1,2'd0,0,32'h8000_0000,1,16'hFFFF));
    @(posedge clk); #1;
    @(negedge clk);
    expect_now("sat_hold", mk(1,1,0,1,2'd0,0,32'h8000_0000,1,16'hFFFF));
    #2 reset = 1'b1;
    #1 expect_now("sat_rst", mk(0,0,0,0,2'd0,0,32'h8000_0000,1,16'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), with clock and reset first:
- clk  in  1  pipeline clock
- reset  in  1  reset, asynchronous, active-high
- ID_rs, ID_rt  in  5  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1  ID instruction reads rs / rt
- ID_valid  in  1  ID slot holds a real instruction, not a bubble
- ID_PC  in  32  PC of the ID instruction
- ID_illop  in  1  ID instruction is an undefined opcode
- ID_eret  in  1  ID instruction is eret
- ID_jump  in  1  ID instruction is j/jal/jr/jalr
- EX_MemRd  in  1  EX instruction is a load
- EX_WrReg  in  5  EX destination register
- EX_branch_taken  in  1  EX branch resolved taken
- irq  in  1  level-sensitive timer interrupt request
- stall_PC  out  1  hold PC
- stall_IFID  out  1  hold IF/ID register
- flush_IFID  out  1  load a bubble into IF/ID
- bubble_IDEX  out  1  drives the ID/EX stall input; zeroes MemWr/MemRd/RegWr
- pc_sel  out  2  0 = normal, 1 = 0x80000004 (interrupt), 2 = 0x80000008 (exception)
- epc  out  32  saved return PC
- kmode  out  1  kernel mode / interrupts masked
- irq_ack  out  1  one-cycle interrupt accept pulse
- stall_cnt  out  16  saturating count of load-use stall cycles
REQ-002 The clock SHALL be clk, and reset SHALL be reset, asynchronous, active-high.

Function
REQ-003 The hazard terms SHALL be defined as follows:
- lu = EX_MemRd & (EX_WrReg != 0) & ((ID_UsesRs & EX_WrReg == ID_rs) | (ID_UsesRt & EX_WrReg == ID_rt))
- take_irq = irq & ~kmode & ~ID_PC[31] & ID_valid
- take_exc = ID_illop & ID_valid
REQ-004 Priority, highest first, one action per cycle: branch, exception, interrupt, load-use, jump, none.
REQ-005 Branch (EX_branch_taken=1) SHALL produce flush_IFID=1, bubble_IDEX=1, stall_PC=0, stall_IFID=0 and pc_sel=0; any exception, interrupt or load-use in the same cycle SHALL be discarded.
REQ-006 Exception SHALL produce, in the same cycle: flush_IFID=1, bubble_IDEX=1, pc_sel=2. On the next edge it SHALL set epc <= ID_PC+4 and kmode <= 1.
REQ-007 Interrupt SHALL produce, in the same cycle: flush_IFID=1, bubble_IDEX=1, pc_sel=1, irq_ack=1. On the next edge it SHALL set epc <= ID_PC and kmode <= 1.
REQ-008 Load-use SHALL produce stall_PC=1, stall_IFID=1, bubble_IDEX=1 and flush_IFID=0 for exactly one cycle; the following cycle SHALL see EX_MemRd=0 because of the bubble, so lu deasserts naturally.
REQ-009 Jump SHALL produce flush_IFID=1 only, for one cycle.
REQ-010 The stall/flush outputs, pc_sel and irq_ack SHALL be combinational from the inputs and registered state; epc, kmode and stall_cnt SHALL be registered.
REQ-011 kmode SHALL clear on the clock edge where ID_eret & ID_valid is true and no higher-priority action (branch, exception, load-use) is active.
REQ-012 eret and take_irq in the same cycle: eret's kmode clear wins on that edge; the interrupt is not taken that cycle (kmode still 1) and is taken on the first eligible cycle after.
REQ-013 take_exc SHALL be honoured regardless of kmode; nested entry overwrites epc.
REQ-014 stall_cnt SHALL increment by 1 on each edge where the load-use action is selected and SHALL saturate at 0xFFFF.
REQ-015 When no action is selected, all stall/flush outputs SHALL be 0, pc_sel=0 and irq_ack=0.

Reset
REQ-016 While reset=1: epc=0x80000000, kmode=1, stall_cnt=0, pc_sel=0, and all stall/flush/ack outputs = 0, independent of clk.
REQ-017 Reset asserted mid-stall or mid-exception entry SHALL abort the action with no register update after reset rises.
REQ-018 The first clock edge after reset release SHALL perform normal evaluation.

Verification
REQ-019 Load-use: EX_MemRd=1, EX_WrReg=8, ID_rs=8, ID_UsesRs=1 -> stall_PC=stall_IFID=bubble_IDEX=1 for 1 cycle; stall_cnt 0->1.
REQ-020 No hazard on $zero: EX_MemRd=1, EX_WrReg=0, ID_rt=0, ID_UsesRt=1 -> all outputs 0, stall_cnt unchanged.
REQ-021 Interrupt: kmode=0, ID_PC=0x00400010, irq=1, ID_valid=1 -> pc_sel=1, irq_ack=1, flush_IFID=bubble_IDEX=1; next cycle epc=0x00400010, kmode=1; a following irq is ignored until eret.
REQ-022 Branch vs exception: EX_branch_taken=1 and ID_illop=1 together -> pc_sel=0, flush_IFID=bubble_IDEX=1, epc and kmode unchanged.
REQ-023 Illegal op: ID_PC=0x00400020, ID_illop=1 -> pc_sel=2; next cycle epc=0x00400024.
REQ-024 Saturation and reset: force 65536 load-use cycles -> stall_cnt holds 0xFFFF; assert reset asynchronously mid-cycle -> stall_cnt=0, kmode=1, epc=0x80000000 immediately.
